// File: rtl/bad_packet_filter_s2.sv
// Bad-packet filter stage 2: pops one BPI entry per packet, then forwards or drains it.
// Optional macro BPF_S2_SATURATE_EN: counters saturate instead of wrapping.
//
// Ports:
//   clk, resetn (async, active low), clear_counters (sync clear of both counters)
//   fpkt_out_*    : packet FIFO read side (tdata/tkeep/tlast/tvalid in, tready out)
//   fbpi_out_*    : BPI FIFO read side (tdata[0]=1 marks a bad packet)
//   AXIS_OUT_*    : filtered output stream
//   good_packets  : packets forwarded
//   bad_packets   : packets dropped
//   drop_pulse    : one-cycle pulse after a dropped packet completes
module bad_packet_filter_s2 #(
   parameter int DATA_WBITS  = 512,
   parameter int DATA_WBYTS  = DATA_WBITS/8,
   parameter int COUNT_WBITS = 32
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   clear_counters,
   input  logic [DATA_WBITS-1:0]  fpkt_out_tdata,
   input  logic [DATA_WBYTS-1:0]  fpkt_out_tkeep,
   input  logic                   fpkt_out_tlast,
   input  logic                   fpkt_out_tvalid,
   output logic                   fpkt_out_tready,
   input  logic [7:0]             fbpi_out_tdata,
   input  logic                   fbpi_out_tvalid,
   output logic                   fbpi_out_tready,
   output logic [DATA_WBITS-1:0]  AXIS_OUT_TDATA,
   output logic [DATA_WBYTS-1:0]  AXIS_OUT_TKEEP,
   output logic                   AXIS_OUT_TLAST,
   output logic                   AXIS_OUT_TVALID,
   input  logic                   AXIS_OUT_TREADY,
   output logic [COUNT_WBITS-1:0] good_packets,
   output logic [COUNT_WBITS-1:0] bad_packets,
   output logic                   drop_pulse
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FWD,
      S_DROP
   } state_t;

   state_t state, state_nxt;
   logic   good_inc, bad_inc;
   logic [COUNT_WBITS-1:0] good_nxt, bad_nxt;

   // Data is a straight pass-through; it is only meaningful while TVALID is high.
   assign AXIS_OUT_TDATA = fpkt_out_tdata;
   assign AXIS_OUT_TKEEP = fpkt_out_tkeep;
   assign AXIS_OUT_TLAST = fpkt_out_tlast;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      fbpi_out_tready = 1'b0;
      fpkt_out_tready = 1'b0;
      AXIS_OUT_TVALID = 1'b0;
      good_inc        = 1'b0;
      bad_inc         = 1'b0;
      unique case (state)
         S_IDLE: begin
            fbpi_out_tready = 1'b1;
            if (fbpi_out_tvalid)
               state_nxt = fbpi_out_tdata[0] ? S_DROP : S_FWD;
         end
         S_FWD: begin
            AXIS_OUT_TVALID = fpkt_out_tvalid;
            fpkt_out_tready = AXIS_OUT_TREADY;
            if (fpkt_out_tvalid && AXIS_OUT_TREADY && fpkt_out_tlast) begin
               good_inc  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_DROP: begin
            fpkt_out_tready = 1'b1;
            if (fpkt_out_tvalid && fpkt_out_tlast) begin
               bad_inc   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef BPF_S2_SATURATE_EN
   localparam logic [COUNT_WBITS-1:0] CNT_MAX = '1;
   assign good_nxt = (good_packets == CNT_MAX) ? good_packets
                                               : good_packets + COUNT_WBITS'(1);
   assign bad_nxt  = (bad_packets == CNT_MAX) ? bad_packets
                                              : bad_packets + COUNT_WBITS'(1);
`else
   assign good_nxt = good_packets + COUNT_WBITS'(1);
   assign bad_nxt  = bad_packets + COUNT_WBITS'(1);
`endif

   // Clear takes priority over a same-cycle increment.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         good_packets <= '0;
         bad_packets  <= '0;
         drop_pulse   <= 1'b0;
      end else begin
         drop_pulse <= bad_inc;
         if (clear_counters) begin
            good_packets <= '0;
            bad_packets  <= '0;
         end else begin
            if (good_inc) good_packets <= good_nxt;
            if (bad_inc)  bad_packets  <= bad_nxt;
         end
      end
   end

endmodule

// File: tb/tb_bad_packet_filter_s2.sv
// Directed bench for bad_packet_filter_s2.
// Table of per-cycle vectors plus wrap/saturate and async-reset sequences.
module tb_bad_packet_filter_s2;

   localparam int DW = 32;
   localparam int DB = DW/8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          clear_counters;
   logic [DW-1:0] pd;
   logic [DB-1:0] pk;
   logic          pl, pv, ppr;
   logic [7:0]    bd;
   logic          bv, bpr;
   logic [DW-1:0] od;
   logic [DB-1:0] ok;
   logic          ol, ov, rdy;
   logic [CW-1:0] good, bad;
   logic          drp;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bad_packet_filter_s2 #(
      .DATA_WBITS (DW),
      .DATA_WBYTS (DB),
      .COUNT_WBITS(CW)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .clear_counters (clear_counters),
      .fpkt_out_tdata (pd),
      .fpkt_out_tkeep (pk),
      .fpkt_out_tlast (pl),
      .fpkt_out_tvalid(pv),
      .fpkt_out_tready(ppr),
      .fbpi_out_tdata (bd),
      .fbpi_out_tvalid(bv),
      .fbpi_out_tready(bpr),
      .AXIS_OUT_TDATA (od),
      .AXIS_OUT_TKEEP (ok),
      .AXIS_OUT_TLAST (ol),
      .AXIS_OUT_TVALID(ov),
      .AXIS_OUT_TREADY(rdy),
      .good_packets   (good),
      .bad_packets    (bad),
      .drop_pulse     (drp)
   );

   typedef struct {
      logic          bv;
      logic [7:0]    bd;
      logic          pv;
      logic [DW-1:0] pd;
      logic          pl;
      logic          rdy;
      logic          clr;
      logic          e_bpr;
      logic          e_ppr;
      logic          e_ov;
      logic          e_ol;
      int            e_good;
      int            e_bad;
      logic          e_drp;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(
      logic b_v, logic [7:0] b_d, logic p_v, logic [DW-1:0] p_d,
      logic p_l, logic r, logic c, logic xbpr, logic xppr, logic xov,
      logic xol, int xg, int xb, logic xdp);
      vec_t v;
      v.bv = b_v; v.bd = b_d; v.pv = p_v; v.pd = p_d;
      v.pl = p_l; v.rdy = r; v.clr = c;
      v.e_bpr = xbpr; v.e_ppr = xppr; v.e_ov = xov; v.e_ol = xol;
      v.e_good = xg; v.e_bad = xb; v.e_drp = xdp;
      return v;
   endfunction

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic b_v, logic [7:0] b_d, logic p_v,
                        logic [DW-1:0] p_d, logic p_l, logic r, logic c);
      @(posedge clk);
      #1;
      bv = b_v; bd = b_d; pv = p_v; pd = p_d;
      pk = p_d[DB-1:0]; pl = p_l; rdy = r; clear_counters = c;
   endtask

   initial begin
      int exp_g;
      tbl[0]  = mk(1, 8'h00, 0, 32'h0,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 8'h00, 1, 32'hD0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 8'h00, 1, 32'hD1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[3]  = mk(0, 8'h00, 1, 32'hD2, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[4]  = mk(0, 8'h00, 1, 32'hD3, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0);
      tbl[5]  = mk(1, 8'h01, 0, 32'h0,  0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
      tbl[6]  = mk(0, 8'h00, 1, 32'hE0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
      tbl[7]  = mk(0, 8'h00, 1, 32'hE1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
      tbl[8]  = mk(0, 8'h00, 1, 32'hE2, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0);
      tbl[9]  = mk(0, 8'h00, 0, 32'h0,  0, 1, 0, 1, 0, 0, 0, 1, 1, 1);
      tbl[10] = mk(1, 8'h00, 0, 32'h0,  0, 1, 0, 1, 0, 0, 0, 1, 1, 0);
      tbl[11] = mk(0, 8'h00, 1, 32'hA1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0);
      tbl[12] = mk(0, 8'h00, 1, 32'hA1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0);
      tbl[13] = mk(1, 8'h01, 0, 32'h0,  0, 1, 0, 1, 0, 0, 0, 2, 1, 0);
      tbl[14] = mk(0, 8'h00, 1, 32'hB1, 1, 0, 0, 0, 1, 0, 0, 2, 1, 0);
      tbl[15] = mk(1, 8'h00, 0, 32'h0,  0, 1, 0, 1, 0, 0, 0, 2, 2, 1);
      tbl[16] = mk(0, 8'h00, 1, 32'hC1, 1, 0, 0, 0, 0, 1, 1, 2, 2, 0);
      tbl[17] = mk(0, 8'h00, 1, 32'hC1, 1, 1, 0, 0, 1, 1, 1, 2, 2, 0);
      tbl[18] = mk(1, 8'hFE, 0, 32'h0,  0, 1, 0, 1, 0, 0, 0, 3, 2, 0);
      tbl[19] = mk(1, 8'h01, 1, 32'hF1, 1, 1, 0, 0, 1, 1, 1, 3, 2, 0);
      tbl[20] = mk(0, 8'h00, 1, 32'h99, 0, 1, 0, 1, 0, 0, 0, 4, 2, 0);
      tbl[21] = mk(1, 8'h00, 0, 32'h0,  0, 1, 0, 1, 0, 0, 0, 4, 2, 0);
      tbl[22] = mk(0, 8'h00, 0, 32'h0,  0, 1, 0, 0, 1, 0, 0, 4, 2, 0);
      tbl[23] = mk(0, 8'h00, 1, 32'h11, 1, 1, 1, 0, 1, 1, 1, 4, 2, 0);
      tbl[24] = mk(0, 8'h00, 0, 32'h0,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0);

      resetn = 1'b0;
      clear_counters = 1'b0;
      bv = 0; bd = 0; pv = 0; pd = 0; pk = 0; pl = 0; rdy = 0;
      #12;
      chk("rst_bpi_rdy", DW'(bpr), 1);
      chk("rst_pkt_rdy", DW'(ppr), 0);
      chk("rst_valid",   DW'(ov),  0);
      chk("rst_good",    DW'(good), 0);
      chk("rst_bad",     DW'(bad), 0);
      chk("rst_drop",    DW'(drp), 0);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].bv, tbl[i].bd, tbl[i].pv, tbl[i].pd,
               tbl[i].pl, tbl[i].rdy, tbl[i].clr);
         @(negedge clk);
         chk($sformatf("r%0d_bpi_rdy", i), DW'(bpr), DW'(tbl[i].e_bpr));
         chk($sformatf("r%0d_pkt_rdy", i), DW'(ppr), DW'(tbl[i].e_ppr));
         chk($sformatf("r%0d_valid", i),   DW'(ov),  DW'(tbl[i].e_ov));
         chk($sformatf("r%0d_good", i),    DW'(good), DW'(tbl[i].e_good));
         chk($sformatf("r%0d_bad", i),     DW'(bad), DW'(tbl[i].e_bad));
         chk($sformatf("r%0d_drop", i),    DW'(drp), DW'(tbl[i].e_drp));
         if (tbl[i].e_ov) begin
            chk($sformatf("r%0d_data", i), od, tbl[i].pd);
            chk($sformatf("r%0d_keep", i), DW'(ok), DW'(tbl[i].pd[DB-1:0]));
            chk($sformatf("r%0d_last", i), DW'(ol), DW'(tbl[i].e_ol));
         end
      end

      // 17 good 1-beat packets into a 4-bit counter
      for (int p = 0; p < 17; p++) begin
         drive(1, 8'h00, 0, 32'h0, 0, 1, 0);
         drive(0, 8'h00, 1, 32'(p), 1, 1, 0);
      end
      drive(0, 8'h00, 0, 32'h0, 0, 1, 0);
      @(negedge clk);
`ifdef BPF_S2_SATURATE_EN
      exp_g = 15;
`else
      exp_g = 1;
`endif
      chk("ovf_good", DW'(good), DW'(exp_g));
      chk("ovf_bad",  DW'(bad), 0);

      // bad packet, then async reset during beat 2 of a 5-beat good packet
      drive(1, 8'h01, 0, 32'h0, 0, 1, 0);
      drive(0, 8'h00, 1, 32'h5, 1, 1, 0);
      drive(1, 8'h00, 0, 32'h0, 0, 1, 0);
      drive(0, 8'h00, 1, 32'h20, 0, 1, 0);
      drive(0, 8'h00, 1, 32'h21, 0, 1, 0);
      @(negedge clk);
      chk("pre_rst_valid", DW'(ov), 1);
      chk("pre_rst_bad",   DW'(bad), 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("ar_bpi_rdy", DW'(bpr), 1);
      chk("ar_pkt_rdy", DW'(ppr), 0);
      chk("ar_valid",   DW'(ov),  0);
      chk("ar_good",    DW'(good), 0);
      chk("ar_bad",     DW'(bad), 0);
      chk("ar_drop",    DW'(drp), 0);
      @(negedge clk);
      resetn = 1'b1;

      drive(1, 8'h00, 0, 32'h0, 0, 1, 0);
      drive(0, 8'h00, 1, 32'h77, 1, 1, 0);
      @(negedge clk);
      chk("post_rst_data", od, 32'h77);
      drive(0, 8'h00, 0, 32'h0, 0, 1, 0);
      @(negedge clk);
      chk("post_rst_good", DW'(good), 1);
      chk("post_rst_idle", DW'(bpr), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bad_packet_filter_s2.md
Name: bad_packet_filter_s2

Overview:
- Second stage of the bad-packet filter; consumes the packet FIFO and the bad-packet-indicator (BPI) FIFO that stage 1 fills.
- For each packet it pops one BPI entry first, then either forwards every beat of the packet to AXIS_OUT or silently drains it.
- Keeps good-packet and bad-packet counters for status registers.

Parameters:
- DATA_WBITS, 512, packet data width in bits.
- DATA_WBYTS, DATA_WBITS/8, TKEEP width.
- COUNT_WBITS, 32, width of the packet counters.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous, active-low reset.
- clear_counters  input  1  synchronous clear of both counters.
- fpkt_out_tdata  input  DATA_WBITS  packet FIFO read data.
- fpkt_out_tkeep  input  DATA_WBYTS  packet FIFO byte enables.
- fpkt_out_tlast  input  1  last beat of a packet.
- fpkt_out_tvalid  input  1  packet FIFO has data.
- fpkt_out_tready  output  1  pop packet FIFO.
- fbpi_out_tdata  input  8  BPI entry; bit 0 = 1 means bad packet; bits 7:1 ignored.
- fbpi_out_tvalid  input  1  BPI FIFO has an entry.
- fbpi_out_tready  output  1  pop BPI FIFO.
- AXIS_OUT_TDATA  output  DATA_WBITS  filtered stream data.
- AXIS_OUT_TKEEP  output  DATA_WBYTS  filtered stream byte enables.
- AXIS_OUT_TLAST  output  1  filtered stream end of packet.
- AXIS_OUT_TVALID  output  1  filtered stream valid.
- AXIS_OUT_TREADY  input  1  downstream ready.
- good_packets  output  COUNT_WBITS  packets forwarded.
- bad_packets  output  COUNT_WBITS  packets dropped.
- drop_pulse  output  1  one-cycle pulse when a dropped packet completes.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = S_IDLE.
  - good_packets = 0, bad_packets = 0, drop_pulse = 0.
  - Every output handshake signal goes low through the combinational decode of S_IDLE, except fbpi_out_tready.
- State S_IDLE:
  - fbpi_out_tready = 1; fpkt_out_tready = 0; AXIS_OUT_TVALID = 0.
  - On a BPI handshake (tvalid & tready): go to S_DROP if fbpi_out_tdata[0] = 1, otherwise go to S_FWD.
  - Packet FIFO contents are never touched in S_IDLE.
- State S_FWD (combinational pass-through, zero latency):
  - AXIS_OUT_TDATA/TKEEP/TLAST = fpkt_out_*.
  - AXIS_OUT_TVALID = fpkt_out_tvalid; fpkt_out_tready = AXIS_OUT_TREADY; fbpi_out_tready = 0.
  - On a handshake with fpkt_out_tlast = 1: good_packets +1, next state S_IDLE.
- State S_DROP:
  - fpkt_out_tready = 1; AXIS_OUT_TVALID = 0; fbpi_out_tready = 0.
  - On fpkt_out_tvalid & fpkt_out_tlast: bad_packets +1, drop_pulse = 1 for the next cycle, next state S_IDLE.
- Throughput: one S_IDLE cycle per packet. Minimum packet period is beats+1 cycles.
- A BPI entry arriving before its packet data is normal; the FSM waits in S_FWD/S_DROP with fpkt_out_tvalid low.
- A 1-beat packet (tlast on first beat) is legal in both paths.
- AXIS_OUT_TDATA/TKEEP/TLAST are don't-care whenever AXIS_OUT_TVALID = 0.
- Counters:
  - clear_counters = 1 zeroes both counters on the next edge.
  - Clear wins over a simultaneous increment.
  - Overflow handling is set by the optional feature.
- Reset mid-packet returns the FSM to S_IDLE. The remaining beats in the FIFOs are not resynchronised; the FIFOs must be reset together with this block.

Optional Feature:
- Macro BPF_S2_SATURATE_EN.
- Defined: counters saturate at 2^COUNT_WBITS-1.
- Undefined: counters wrap modulo 2^COUNT_WBITS.
- FSM and data path are identical in both cases.

Test Plan:
- BPI = 0x00, 4-beat packet D0..D3, AXIS_OUT_TREADY = 1 -> D0..D3 out on 4 consecutive cycles with TLAST on D3; good_packets = 1; bad_packets = 0.
- BPI = 0x01, 3-beat packet -> AXIS_OUT_TVALID stays 0; the packet FIFO drains in 3 cycles; bad_packets = 1; one drop_pulse.
- Alternating good/bad/good 1-beat packets with TREADY toggling every cycle -> only packets 1 and 3 appear, each held stable until accepted; counts 2/1.
- BPI = 0xFE (bit 0 = 0) -> packet forwarded (upper bits ignored).
- COUNT_WBITS = 4, 17 good packets -> good_packets = 15 with BPF_S2_SATURATE_EN defined, 1 without; clear_counters asserted on the same cycle as an increment -> 0.
- Assert resetn low during beat 2 of 5 -> all counters 0, state S_IDLE, fbpi_out_tready = 1 immediately (asynchronous).
